// File: rtl/npu_pkg.sv
// Shared NPU constants and the weight-loader state encoding.
package npu_pkg;

  localparam int NUM_WEIGHTS = 192;
  localparam int DATA_W      = 16;
  localparam int WL_IDX_W    = $clog2(NUM_WEIGHTS + 1);

  typedef enum logic [1:0] {
    WL_IDLE   = 2'd0,
    WL_LOAD   = 2'd1,
    WL_COMMIT = 2'd2,
    WL_DRAIN  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/weight_csum.sv
// Running mod-2^DATA_W sum of loaded weights with an equality flag against a
// candidate checksum word. Only instantiated when WEIGHT_LOADER_CHECKSUM_EN is set.
module weight_csum
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] cmp_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              match_o
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o   = sum_q;
  assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/weight_loader.sv
// Streams a frame of weights into a staging bank and commits it atomically to the
// live bank. Optional trailing checksum word enabled by WEIGHT_LOADER_CHECKSUM_EN.
//
// state     | meaning
// WL_IDLE   | waiting for start_i, stream not ready
// WL_LOAD   | accepting words into the staging bank
// WL_COMMIT | copy staging -> live, pulse done
// WL_DRAIN  | long frame: discard words until s_last
module weight_loader
  import npu_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [NUM_WEIGHTS*DATA_W-1:0] weights_o,
  output logic                          weights_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_WEIGHTS + 1;
`else
  localparam int FRAME_LEN = NUM_WEIGHTS;
`endif

  wl_state_e                   state_q, state_d;
  logic [WL_IDX_W-1:0]         idx_q, idx_d;
  logic                        error_q, error_d;
  logic                        done_q, done_d;
  logic                        valid_q;
  logic                        commit;
  logic [DATA_W-1:0]           staging_q [NUM_WEIGHTS];
  logic [NUM_WEIGHTS*DATA_W-1:0] live_q;

  logic hs, last_word, stg_we;

  assign s_ready   = (state_q == WL_LOAD) || (state_q == WL_DRAIN);
  assign hs        = s_valid && s_ready;
  assign last_word = (idx_q == WL_IDX_W'(FRAME_LEN - 1));
  assign stg_we    = (state_q == WL_LOAD) && hs && (idx_q < WL_IDX_W'(NUM_WEIGHTS));

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic csum_ok;

  // The checksum word itself arrives with idx == NUM_WEIGHTS and must not be summed.
  weight_csum u_csum (
    .clk     (clk),
    .reset   (reset),
    .clear_i ((state_q == WL_IDLE) && start_i),
    .en_i    (stg_we),
    .data_i  (s_data),
    .cmp_i   (s_data),
    .sum_o   (),
    .match_o (csum_ok)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    error_d = error_q;
    done_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      WL_IDLE: begin
        if (start_i) begin
          state_d = WL_LOAD;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      WL_LOAD: begin
        if (hs) begin
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            if (!s_last) begin
              state_d = WL_DRAIN;
              error_d = 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            end else if (!csum_ok) begin
              state_d = WL_IDLE;
              error_d = 1'b1;
`endif
            end else begin
              state_d = WL_COMMIT;
            end
          end else if (s_last) begin
            state_d = WL_IDLE;
            error_d = 1'b1;
          end
        end
      end
      WL_COMMIT: begin
        commit  = 1'b1;
        done_d  = 1'b1;
        state_d = WL_IDLE;
      end
      WL_DRAIN: begin
        if (hs && s_last) state_d = WL_IDLE;
      end
      default: state_d = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WL_IDLE;
      idx_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) staging_q[i] <= '0;
    end else if (stg_we) begin
      staging_q[idx_q] <= s_data;
    end
  end

  // Live bank only changes on a clean commit, so readers keep the old frame on errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q  <= '0;
      valid_q <= 1'b0;
    end else if (commit) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) live_q[i*DATA_W +: DATA_W] <= staging_q[i];
      valid_q <= 1'b1;
    end
  end

  assign weights_o       = live_q;
  assign weights_valid_o = valid_q;
  assign busy_o          = (state_q != WL_IDLE);
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule
